// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: processor-wide definitions shared by the fetch unit and the control unit.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_DONE,
        S_HALTED
    } fetch_state_t;

    localparam logic [7:0] DEFAULT_HALT_OP = 8'hFF;

    // Instruction word layout: opcode in the upper byte, operand in the lower byte.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 8;
    localparam int OPR_MSB = 7;
    localparam int OPR_LSB = 0;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h10;
    localparam logic [7:0] OP_JZ    = 8'h11;

    function automatic logic [7:0] opcode_of(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [7:0] operand_of(input logic [15:0] word);
        return word[OPR_MSB:OPR_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with configurable ROM latency, IR register and PC control pulses.
// All outputs are registered and asserted on entry to the state they belong to.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int         IMEM_LAT = 1,
    parameter logic [7:0] HALT_OP  = DEFAULT_HALT_OP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        jump,
    input  logic [7:0]  pc_in,
    input  logic [15:0] imem_data,
    output logic [7:0]  imem_addr,
    output logic        imem_en,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [7:0]  ir_opcode,
    output logic [7:0]  ir_operand,
    output logic        fetch_done,
    output logic        busy,
    output logic        halted
);

    fetch_state_t state;
    logic [1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            imem_addr  <= '0;
            imem_en    <= 1'b0;
            pc_inc     <= 1'b0;
            pc_load    <= 1'b0;
            ir_opcode  <= '0;
            ir_operand <= '0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            imem_en    <= 1'b0;
            pc_inc     <= 1'b0;
            pc_load    <= 1'b0;
            fetch_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (jump) begin
                        pc_load <= 1'b1;
                    end else if (fetch_req) begin
                        state     <= S_ADDR;
                        imem_addr <= pc_in;
                        imem_en   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state <= S_WAIT;
                    cnt   <= 2'(IMEM_LAT - 1);
                end
                // Data is captured on the edge leaving WAIT, IMEM_LAT cycles after the strobe.
                S_WAIT: begin
                    if (cnt == 2'd0) begin
                        state      <= S_LATCH;
                        ir_opcode  <= opcode_of(imem_data);
                        ir_operand <= operand_of(imem_data);
                        pc_inc     <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_LATCH: begin
                    state      <= S_DONE;
                    fetch_done <= 1'b1;
                end
                S_DONE: begin
                    busy   <= 1'b0;
                    state  <= (ir_opcode == HALT_OP) ? S_HALTED : S_IDLE;
                    halted <= (ir_opcode == HALT_OP);
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios on a latency-1 and a latency-3 fetch unit with ROM and PC models.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0, jump = 1'b0;
    logic        fetch_req3 = 1'b0, jump3 = 1'b0;
    logic [7:0]  pc = 8'h00, pc3 = 8'h00, pc_val = 8'h00;
    logic        pc_wr = 1'b0;
    logic [15:0] d1 = 16'h0000, d3 = 16'h0000;
    logic [15:0] rom [256];
    logic [1:0]  v3 = 2'b00;
    logic [7:0]  a3_0 = 8'h00, a3_1 = 8'h00;

    logic [7:0]  imem_addr, ir_opcode, ir_operand;
    logic        imem_en, pc_inc, pc_load, fetch_done, busy, halted;
    logic [7:0]  imem_addr3, ir_opcode3, ir_operand3;
    logic        imem_en3, pc_inc3, pc_load3, fetch_done3, busy3, halted3;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.IMEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .jump(jump), .pc_in(pc), .imem_data(d1),
        .imem_addr(imem_addr), .imem_en(imem_en), .pc_inc(pc_inc), .pc_load(pc_load),
        .ir_opcode(ir_opcode), .ir_operand(ir_operand), .fetch_done(fetch_done),
        .busy(busy), .halted(halted)
    );

    fetch_unit #(.IMEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req3), .jump(jump3), .pc_in(pc3), .imem_data(d3),
        .imem_addr(imem_addr3), .imem_en(imem_en3), .pc_inc(pc_inc3), .pc_load(pc_load3),
        .ir_opcode(ir_opcode3), .ir_operand(ir_operand3), .fetch_done(fetch_done3),
        .busy(busy3), .halted(halted3)
    );

    always #5 clk = ~clk;

    // ROM models: data appears IMEM_LAT cycles after the strobe and then holds.
    always @(posedge clk) begin
        if (imem_en) d1 <= rom[imem_addr];
        v3   <= {v3[0], imem_en3};
        a3_0 <= imem_addr3;
        a3_1 <= a3_0;
        if (v3[1]) d3 <= rom[a3_1];
    end

    // PC models sample on the falling edge.
    always @(negedge clk) begin
        if (pc_wr) begin
            pc  <= pc_val;
            pc3 <= pc_val;
        end else begin
            if (pc_load) pc <= ir_operand;
            else if (pc_inc) pc <= pc + 8'd1;
            if (pc_load3) pc3 <= ir_operand3;
            else if (pc_inc3) pc3 <= pc3 + 8'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_val = v;
        pc_wr  = 1'b1;
        @(negedge clk);
        #1;
        pc_wr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h exp=0", halted); end
        checks++; if ({imem_addr, ir_opcode, ir_operand} !== 24'h0) begin failures++; $display("FAIL reset_regs got=%0h exp=0", {imem_addr, ir_opcode, ir_operand}); end
        checks++; if ({imem_en, pc_inc, pc_load, fetch_done} !== 4'h0) begin failures++; $display("FAIL reset_pulses got=%0h exp=0", {imem_en, pc_inc, pc_load, fetch_done}); end
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_fetch_lat1();
        int en_c = 0, en_n = 0, inc_c = 0, inc_n = 0, done_c = 0, busy_n = 0;
        set_pc(8'h05);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            if (imem_en) begin en_c = c; en_n++; end
            if (pc_inc) begin inc_c = c; inc_n++; end
            if (fetch_done) done_c = c;
            if (busy) busy_n++;
        end
        checks++; if (en_c !== 1 || en_n !== 1) begin failures++; $display("FAIL lat1_imem_en got=c%0d n%0d exp=c1 n1", en_c, en_n); end
        checks++; if (inc_c !== 3 || inc_n !== 1) begin failures++; $display("FAIL lat1_pc_inc got=c%0d n%0d exp=c3 n1", inc_c, inc_n); end
        checks++; if (done_c !== 4) begin failures++; $display("FAIL lat1_fetch_done got=c%0d exp=c4", done_c); end
        checks++; if (busy_n !== 4) begin failures++; $display("FAIL lat1_busy got=%0d exp=4", busy_n); end
        checks++; if ({ir_opcode, ir_operand} !== 16'h1234) begin failures++; $display("FAIL lat1_ir got=%h exp=1234", {ir_opcode, ir_operand}); end
        checks++; if (pc !== 8'h06 || imem_addr !== 8'h05) begin failures++; $display("FAIL lat1_pc_addr got=%h/%h exp=06/05", pc, imem_addr); end
    endtask

    task automatic test_ignore_while_busy();
        int en_n = 0, ld_n = 0, done_c = 0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) step();
            if (imem_en) en_n++;
            if (pc_load) ld_n++;
            if (fetch_done) done_c = c;
            jump      = (c < 4);
            fetch_req = (c < 4);
        end
        checks++; if (en_n !== 1 || ld_n !== 0) begin failures++; $display("FAIL busy_ignore got=en%0d ld%0d exp=en1 ld0", en_n, ld_n); end
        checks++; if (done_c !== 4) begin failures++; $display("FAIL busy_done got=c%0d exp=c4", done_c); end
        checks++; if ({ir_opcode, ir_operand} !== 16'h0140 || pc !== 8'h07) begin failures++; $display("FAIL busy_ir_pc got=%h/%h exp=0140/07", {ir_opcode, ir_operand}, pc); end
    endtask

    task automatic test_jump_priority();
        jump = 1'b1;
        fetch_req = 1'b1;
        step();
        jump = 1'b0;
        fetch_req = 1'b0;
        checks++; if (pc_load !== 1'b1 || imem_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL jump_c1 got=ld%0h en%0h busy%0h exp=ld1 en0 busy0", pc_load, imem_en, busy); end
        step();
        checks++; if (pc_load !== 1'b0 || imem_en !== 1'b0) begin failures++; $display("FAIL jump_c2 got=ld%0h en%0h exp=ld0 en0", pc_load, imem_en); end
        checks++; if (pc !== 8'h40) begin failures++; $display("FAIL jump_pc got=%h exp=40", pc); end
    endtask

    task automatic test_wrap();
        int inc_n = 0;
        set_pc(8'hFF);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        checks++; if (imem_addr !== 8'hFF || imem_en !== 1'b1) begin failures++; $display("FAIL wrap_addr got=%h en%0h exp=ff en1", imem_addr, imem_en); end
        for (int c = 2; c <= 5; c++) begin
            step();
            if (pc_inc) inc_n++;
        end
        checks++; if (pc !== 8'h00 || inc_n !== 1) begin failures++; $display("FAIL wrap_pc got=%h n%0d exp=00 n1", pc, inc_n); end
        checks++; if ({ir_opcode, ir_operand} !== 16'h2233) begin failures++; $display("FAIL wrap_ir got=%h exp=2233", {ir_opcode, ir_operand}); end
    endtask

    task automatic test_reset_mid_fetch();
        int seen = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_pc(8'h10);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_wait_busy got=%0h exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || imem_addr !== 8'h00 || imem_en !== 1'b0) begin failures++; $display("FAIL midrst_async got=busy%0h addr%h exp=busy0 addr00", busy, imem_addr); end
        checks++; if ({ir_opcode, ir_operand} !== 16'h0000) begin failures++; $display("FAIL midrst_ir got=%h exp=0000", {ir_opcode, ir_operand}); end
        for (int c = 0; c < 2; c++) begin
            step();
            if (pc_inc || fetch_done) seen++;
        end
        rst = 1'b0;
        step();
        if (pc_inc || fetch_done) seen++;
        checks++; if (seen !== 0 || pc !== 8'h10) begin failures++; $display("FAIL midrst_abort got=pulses%0d pc%h exp=pulses0 pc10", seen, pc); end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        checks++; if (imem_en !== 1'b1 || imem_addr !== 8'h10) begin failures++; $display("FAIL postrst_fetch got=en%0h addr%h exp=en1 addr10", imem_en, imem_addr); end
        for (int c = 2; c <= 5; c++) step();
        checks++; if ({ir_opcode, ir_operand} !== 16'h5566 || pc !== 8'h11) begin failures++; $display("FAIL postrst_ir got=%h/%h exp=5566/11", {ir_opcode, ir_operand}, pc); end
    endtask

    task automatic test_lat3();
        int en_c = 0, en_n = 0, inc_c = 0, inc_n = 0, done_c = 0;
        set_pc(8'h05);
        fetch_req3 = 1'b1;
        step();
        fetch_req3 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) step();
            if (imem_en3) begin en_c = c; en_n++; end
            if (pc_inc3) begin inc_c = c; inc_n++; end
            if (fetch_done3) done_c = c;
        end
        checks++; if (en_c !== 1 || en_n !== 1) begin failures++; $display("FAIL lat3_imem_en got=c%0d n%0d exp=c1 n1", en_c, en_n); end
        checks++; if (inc_c !== 5 || inc_n !== 1) begin failures++; $display("FAIL lat3_pc_inc got=c%0d n%0d exp=c5 n1", inc_c, inc_n); end
        checks++; if (done_c !== 6) begin failures++; $display("FAIL lat3_fetch_done got=c%0d exp=c6", done_c); end
        checks++; if ({ir_opcode3, ir_operand3} !== 16'h1234 || pc3 !== 8'h06) begin failures++; $display("FAIL lat3_ir_pc got=%h/%h exp=1234/06", {ir_opcode3, ir_operand3}, pc3); end
    endtask

    task automatic test_halt();
        int done_c = 0, en_n = 0, ld_n = 0;
        set_pc(8'h07);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step();
            if (fetch_done) done_c = c;
        end
        checks++; if (done_c !== 4) begin failures++; $display("FAIL halt_done got=c%0d exp=c4", done_c); end
        checks++; if (halted !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL halt_state got=h%0h b%0h exp=h1 b0", halted, busy); end
        fetch_req = 1'b1;
        jump = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (imem_en) en_n++;
            if (pc_load) ld_n++;
        end
        fetch_req = 1'b0;
        jump = 1'b0;
        checks++; if (en_n !== 0 || ld_n !== 0 || halted !== 1'b1) begin failures++; $display("FAIL halt_ignore got=en%0d ld%0d h%0h exp=en0 ld0 h1", en_n, ld_n, halted); end
        rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset got=%0h exp=0", halted); end
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h05] = 16'h1234;
        rom[8'h06] = 16'h0140;
        rom[8'h07] = 16'hFF00;
        rom[8'h10] = 16'h5566;
        rom[8'hFF] = 16'h2233;
        #2;
        test_reset();
        test_fetch_lat1();
        test_ignore_while_busy();
        test_jump_priority();
        test_wrap();
        test_reset_mid_fetch();
        test_lat3();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
